// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package rr_arbiter4_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter4_dec.sv
// 2-to-4 enable decoder: one-hot output selected by a, all zero when e is low.
module decoder2to4 (
    input  logic [1:0] a,
    input  logic       e,
    output logic [3:0] y
);

    // Drive the selected line only while enabled
    always_comb begin
        y = 4'b0000;
        if (e) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a programmable grant hold limit.
// Ownership is held in registers; all outputs are decoded from them.
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid
);

    localparam int               HOLD_M1   = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HOLD_SAT  = HOLD_MAX[CNT_W-1:0];

    arb_state_t       state;
    logic [1:0]       owner;
    logic [1:0]       last;
    logic [CNT_W-1:0] hold_cnt;

    logic [3:0]       others;
    logic             rotate;

    // First set bit of r scanning from ptr+1 upward with wrap; ptr itself last.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        pick = ptr;
        for (int k = NREQ; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    // Decide whether the current owner gives up the grant this cycle.
    // A counter already saturated (owner was alone) counts as expired, so a
    // late newcomer still gets its turn.
    always_comb begin
        others         = req;
        others[owner]  = 1'b0;
        rotate         = !req[owner]
                       || ((HOLD_MAX != 0) && (hold_cnt >= HOLD_LAST) && (others != 4'b0000));
    end

    // Ownership state machine with rotating priority pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= 2'd0;
            last     <= 2'd3;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 4'b0000) begin
                        owner    <= pick(req, last);
                        hold_cnt <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rotate) begin
                        last     <= owner;
                        hold_cnt <= '0;
                        if (others != 4'b0000) begin
                            owner <= pick(others, owner);
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (hold_cnt < HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state
    always_comb begin
        gnt_valid = (state == ST_BUSY);
        gnt_id    = gnt_valid ? owner : 2'd0;
    end

    decoder2to4 u_dec (
        .a (owner),
        .e (gnt_valid),
        .y (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance with HOLD_MAX=2, one with HOLD_MAX=0.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;

    logic [3:0] gnt_a, gnt_z;
    logic [1:0] id_a, id_z;
    logic       vld_a, vld_z;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.HOLD_MAX(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(vld_a)
    );

    rr_arbiter4 #(.HOLD_MAX(0), .CNT_W(4)) dut_z (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt_z), .gnt_id(id_z), .gnt_valid(vld_z)
    );

    // Expected {gnt_valid, gnt_id, gnt} when requester o owns the grant
    function automatic logic [6:0] busy_vec(input int o);
        logic [1:0] id;
        logic [3:0] oh;
        id = o[1:0];
        oh = 4'b0001 << id;
        return {1'b1, id, oh};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", {vld_a, id_a, gnt_a}, 7'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if ({vld_a, id_a, gnt_a} !== 7'b0) begin
                n_fail++;
                $display("FAIL idle_no_req cyc=%0d got=%b want=%b", i, {vld_a, id_a, gnt_a}, 7'b0);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if ({vld_a, id_a, gnt_a} !== busy_vec(2)) begin
                n_fail++;
                $display("FAIL single_grant cyc=%0d got=%b want=%b", i, {vld_a, id_a, gnt_a}, busy_vec(2));
            end
        end
        req = 4'b0000;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== 7'b0) begin
            n_fail++;
            $display("FAIL single_release got=%b want=%b", {vld_a, id_a, gnt_a}, 7'b0);
        end
    endtask

    task automatic test_rotation();
        int exp_own [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if ({vld_a, id_a, gnt_a} !== busy_vec(exp_own[i])) begin
                n_fail++;
                $display("FAIL rotation cyc=%0d got=%b want=%b", i, {vld_a, id_a, gnt_a}, busy_vec(exp_own[i]));
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_pointer();
        do_reset();
        req = 4'b0010;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== busy_vec(1)) begin
            n_fail++;
            $display("FAIL ptr_owner1 got=%b want=%b", {vld_a, id_a, gnt_a}, busy_vec(1));
        end
        req = 4'b1001;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== busy_vec(3)) begin
            n_fail++;
            $display("FAIL ptr_handover got=%b want=%b", {vld_a, id_a, gnt_a}, busy_vec(3));
        end
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== busy_vec(3)) begin
            n_fail++;
            $display("FAIL ptr_hold got=%b want=%b", {vld_a, id_a, gnt_a}, busy_vec(3));
        end
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== busy_vec(0)) begin
            n_fail++;
            $display("FAIL ptr_forced got=%b want=%b", {vld_a, id_a, gnt_a}, busy_vec(0));
        end
        req = 4'b0000;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== 7'b0) begin
            n_fail++;
            $display("FAIL ptr_release got=%b want=%b", {vld_a, id_a, gnt_a}, 7'b0);
        end
    endtask

    task automatic test_hold_disabled();
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if ({vld_z, id_z, gnt_z} !== busy_vec(0)) begin
                n_fail++;
                $display("FAIL hold0_keep cyc=%0d got=%b want=%b", i, {vld_z, id_z, gnt_z}, busy_vec(0));
            end
            n_cmp++;
            if ({vld_a, id_a, gnt_a} !== busy_vec((i / 2) % 2)) begin
                n_fail++;
                $display("FAIL hold2_alt cyc=%0d got=%b want=%b", i, {vld_a, id_a, gnt_a}, busy_vec((i / 2) % 2));
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_alone();
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if ({vld_a, id_a, gnt_a} !== busy_vec(3)) begin
                n_fail++;
                $display("FAIL alone_keep cyc=%0d got=%b want=%b", i, {vld_a, id_a, gnt_a}, busy_vec(3));
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b0100;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== busy_vec(2)) begin
            n_fail++;
            $display("FAIL rstmid_pre got=%b want=%b", {vld_a, id_a, gnt_a}, busy_vec(2));
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear got=%b want=%b", {vld_a, id_a, gnt_a}, 7'b0);
        end
        rst = 1'b0;
        req = 4'b1111;
        step();
        n_cmp++;
        if ({vld_a, id_a, gnt_a} !== busy_vec(0)) begin
            n_fail++;
            $display("FAIL rstmid_first got=%b want=%b", {vld_a, id_a, gnt_a}, busy_vec(0));
        end
        n_cmp++;
        if ({vld_z, id_z, gnt_z} !== busy_vec(0)) begin
            n_fail++;
            $display("FAIL rstmid_first_h0 got=%b want=%b", {vld_z, id_z, gnt_z}, busy_vec(0));
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_pointer();
        test_hold_disabled();
        test_alone();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares a single resource (bus, ALU port, memory bank) between requesters. It sequences ownership with a small state machine and a rotating priority pointer, and holds a grant while the owner keeps requesting, up to a programmable hold limit. It drives a one-hot grant vector through the existing 2-to-4 enable decoder, so downstream logic sees exactly the decoder encoding it already uses.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles one owner keeps the grant while another requester waits; 0 disables the limit.
- CNT_W, 4: hold counter width; requires HOLD_MAX <= 2^CNT_W − 1.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  [3:0]  request lines, bit i = requester i; level-sensitive.
- gnt  output  [3:0]  one-hot grant, all zero when no owner.
- gnt_id  output  [1:0]  binary index of current owner; 0 when gnt_valid=0.
- gnt_valid  output  1  high while a grant is active.

## Operation
- Registers: state (IDLE, BUSY), owner[1:0], last[1:0], hold_cnt[CNT_W-1:0].
- Reset values: state=IDLE, owner=0, last=3 (requester 0 has first priority), hold_cnt=0; outputs gnt=4'b0000, gnt_id=0, gnt_valid=0.
- Pick function: scan req starting at last+1 (mod 4), wrapping; first set bit wins.
- IDLE: if req≠0, owner←pick(req), hold_cnt←0, state←BUSY; else stay.
- BUSY, release (req[owner]=0): last←owner; others=req with bit owner cleared; if others≠0, owner←pick(others), hold_cnt←0, stay BUSY; else state←IDLE.
- BUSY, forced rotation (HOLD_MAX≠0, hold_cnt=HOLD_MAX−1, req[owner]=1, others≠0): handled as release. The old owner re-enters arbitration at lowest priority.
- BUSY, otherwise: keep owner, hold_cnt increments, saturating at HOLD_MAX.
- Outputs are a pure function of registers: gnt_valid=(state==BUSY); gnt=decoder(owner, E=gnt_valid); gnt_id=gnt_valid?owner:0. Outputs are glitch-free and registered-equivalent.
- Invariant: popcount(gnt) ≤ 1 at all times.
- A grant is never given to a requester whose req was low in the deciding cycle.

## Timing
- Request-to-grant latency: 1 cycle. req sampled at edge N, gnt valid after edge N.
- Handover: owner drops req at edge N, and the next owner is granted after the same edge N. There is no dead cycle when others are pending.
- Release with no other requester: gnt goes 0 after edge N, IDLE. A new request then takes 1 further cycle.
- Simultaneous release and new requests: the new requests are included in the same pick.
- Owner alone with HOLD_MAX expired: keeps the grant indefinitely, and hold_cnt saturates.
- Worst-case wait for a continuously requesting requester with HOLD_MAX=H: 3·H cycles.
- rst mid-BUSY: all outputs 0 after the reset edge, and the pointer returns to last=3.
- req changes in the cycle after a grant have no effect until the next edge.

## Structure
- Shared header (`arb_defs.vh`): state encodings ST_IDLE=1'b0, ST_BUSY=1'b1; NREQ=4.
- Sub-module: instantiate the existing `decoder2to4` with A=owner, E=gnt_valid to produce gnt. The pick function is an in-module `function`.
- Expected size about 150 lines.

## Test plan
- Reset, then req=4'b0000 for 5 cycles: gnt=0, gnt_valid=0, gnt_id=0 throughout.
- After reset, req=4'b1111 held, with HOLD_MAX=2: grants rotate 0,0,1,1,2,2,3,3,0… Each owner gets exactly 2 cycles and the grant is never zero between owners.
- req=4'b0100 for 3 cycles, then 0: gnt=4'b0100 and gnt_id=2 starting 1 cycle after the request, for 3 cycles, then 0 one cycle after the drop.
- Owner 1 holds, req=4'b0010, then at edge N req=4'b1001: after N, gnt=4'b1000 (pointer last=1 → 3 precedes 0).
- HOLD_MAX=0, req=4'b0011 held 20 cycles: requester 0 is granted throughout and requester 1 never gets the grant.
- rst pulsed while gnt=4'b0100: gnt=0 the next cycle. With req=4'b1111 after reset, the first grant goes to requester 0.
